// File: rtl/ray_marcher.sv
// Fixed-step ray marcher: walks a point along dir>>>STEP_SHIFT until the SDF
// evaluator reports a hit or MAX_STEPS evaluations pass. Define RAY_MARCHER_BOUNDS_EN to
// also terminate rays whose point leaves the +/-8.0 cube.

module ray_marcher_axis #(
  parameter int STEP_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] o,
  input  logic [15:0] d,
  output logic [15:0] p
);
  logic [15:0]        dir_q;
  logic signed [15:0] step;

  // Kept in its own signed net so the shift stays arithmetic.
  assign step = $signed(dir_q) >>> STEP_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      dir_q <= '0;
    end else if (load) begin
      p     <= o;
      dir_q <= d;
    end else if (adv) begin
      p <= p + step;
    end
  end
endmodule

module ray_marcher #(
  parameter int MAX_STEPS  = 32,
  parameter int STEP_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  logic signed [15:0] ox,
  input  logic signed [15:0] oy,
  input  logic signed [15:0] oz,
  input  logic signed [15:0] dx,
  input  logic signed [15:0] dy,
  input  logic signed [15:0] dz,
  output logic signed [15:0] px,
  output logic signed [15:0] py,
  output logic signed [15:0] pz,
  input  logic               sdf_hit,
  input  logic signed [15:0] sdf_light,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_hit,
  output logic [7:0]         res_shade,
  output logic [5:0]         res_steps
);
  typedef enum logic [1:0] {IDLE, MARCH, DONE} state_t;

  localparam logic [5:0] LAST = 6'(MAX_STEPS - 1);

  state_t          state;
  logic [5:0]      cnt;
  logic [2:0][15:0] org, dirv, pt;
  logic            load, adv, last, oob;

  assign org  = {oz, oy, ox};
  assign dirv = {dz, dy, dx};
  assign px   = pt[0];
  assign py   = pt[1];
  assign pz   = pt[2];

  assign load = (state == IDLE) && ray_valid;
  assign last = (cnt == LAST);
  assign adv  = (state == MARCH) && !sdf_hit && !oob && !last;

  for (genvar g = 0; g < 3; g++) begin : g_axis
    ray_marcher_axis #(.STEP_SHIFT(STEP_SHIFT)) u_axis (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .adv  (adv),
      .o    (org[g]),
      .d    (dirv[g]),
      .p    (pt[g])
    );
  end

`ifdef RAY_MARCHER_BOUNDS_EN
  logic [2:0] lane_oob;
  for (genvar g = 0; g < 3; g++) begin : g_oob
    assign lane_oob[g] = ($signed(pt[g]) >= 16'sh0800) || ($signed(pt[g]) <= -16'sh0800);
  end
  assign oob = |lane_oob;
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ray_ready <= 1'b1;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_shade <= '0;
      res_steps <= '0;
    end else begin
      case (state)
        IDLE: if (ray_valid) begin
          state     <= MARCH;
          cnt       <= '0;
          ray_ready <= 1'b0;
        end
        MARCH: begin
          // Hit outranks both the bounds check and the step limit.
          if (sdf_hit) begin
            res_hit   <= 1'b1;
            res_shade <= (sdf_light >= 16'sh0100) ? 8'hFF : sdf_light[7:0];
            res_steps <= cnt;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (oob || last) begin
            res_hit   <= 1'b0;
            res_shade <= '0;
            res_steps <= cnt;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          ray_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_marcher.sv
// Scoreboarded bench for ray_marcher: a behavioural march model predicts each
// result at accept time; a negedge monitor compares whenever res_valid rises.
`timescale 1ns/1ps
module tb_ray_marcher;
  localparam int MAX_STEPS  = 32;
  localparam int STEP_SHIFT = 2;

  logic clk = 0, rst_n = 0;
  logic ray_valid = 0, ray_ready, res_valid, res_ready = 0, res_hit, sdf_hit;
  logic signed [15:0] ox = 0, oy = 0, oz = 0, dx = 0, dy = 0, dz = 0;
  logic signed [15:0] px, py, pz, sdf_light;
  logic [7:0] res_shade;
  logic [5:0] res_steps;

  ray_marcher #(.MAX_STEPS(MAX_STEPS), .STEP_SHIFT(STEP_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .px(px), .py(py), .pz(pz), .sdf_hit(sdf_hit), .sdf_light(sdf_light),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_shade(res_shade), .res_steps(res_steps));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scene: 0 = always hit, 1 = never hit, 2 = hit when px >= thr
  int mode = 1;
  logic signed [15:0] thr = 0, lbase = 0;

  function automatic logic scene_hit(logic signed [15:0] x, int m, logic signed [15:0] t);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'b0;
    return x >= t;
  endfunction

  function automatic logic signed [15:0] scene_light(logic signed [15:0] x, logic signed [15:0] b);
    return b + {7'b0, x[8:0]};
  endfunction

  always_comb begin
    sdf_hit   = scene_hit(px, mode, thr);
    sdf_light = scene_light(px, lbase);
  end

  typedef struct {
    logic hit; logic [7:0] shade; int steps;
    logic signed [15:0] fx, fy, fz; int lat; int acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Walk the ray: evaluate, terminate on hit / limit / bounds, else advance.
  function automatic exp_t model(logic signed [15:0] x0, y0, z0, ddx, ddy, ddz);
    exp_t e;
    logic signed [15:0] p [3];
    logic signed [15:0] d [3];
    logic signed [15:0] lt;
    logic done;
    p[0] = x0; p[1] = y0; p[2] = z0;
    d[0] = ddx; d[1] = ddy; d[2] = ddz;
    e.hit = 0; e.shade = 0; e.steps = 0; e.acc = 0;
    done = 0;
    for (int n = 0; n < MAX_STEPS && !done; n++) begin
      if (scene_hit(p[0], mode, thr)) begin
        lt = scene_light(p[0], lbase);
        e.hit = 1; e.shade = (lt >= 16'sh0100) ? 8'hFF : lt[7:0];
        e.steps = n; done = 1;
      end else begin
`ifdef RAY_MARCHER_BOUNDS_EN
        for (int i = 0; i < 3; i++)
          if (p[i] >= 16'sh0800 || p[i] <= -16'sh0800) done = 1;
`endif
        if (n == MAX_STEPS - 1) done = 1;
        if (done) e.steps = n;
        else for (int i = 0; i < 3; i++) p[i] = p[i] + (d[i] >>> STEP_SHIFT);
      end
    end
    e.fx = p[0]; e.fy = p[1]; e.fz = p[2];
    e.lat = e.steps + 2;
    return e;
  endfunction

  // Monitor
  logic seen = 0;
  logic last_hit; logic [7:0] last_shade; int last_steps; logic signed [15:0] last_px;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen = 0;
    else if (res_valid && !seen) begin
      seen = 1;
      last_hit = res_hit; last_shade = res_shade; last_steps = res_steps; last_px = px;
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("res_hit", res_hit, e.hit);
        chk("res_shade", res_shade, e.shade);
        chk("res_steps", res_steps, e.steps);
        chk("px_final", px, e.fx);
        chk("py_final", py, e.fy);
        chk("pz_final", pz, e.fz);
        chk("latency", cyc + 1 - e.acc, e.lat);
      end
    end else if (!res_valid) seen = 0;
  end

  task automatic accept(logic signed [15:0] x0, y0, z0, ddx, ddy, ddz);
    exp_t e;
    int k;
    for (k = 0; k < 100 && !ray_ready; k++) @(negedge clk);
    if (!ray_ready) chk("ray_ready_timeout", 0, 1);
    @(negedge clk);
    ray_valid = 1; ox = x0; oy = y0; oz = z0; dx = ddx; dy = ddy; dz = ddz;
    e = model(x0, y0, z0, ddx, ddy, ddz);
    @(posedge clk); #1;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    // Garbage on the inputs while busy must not matter.
    ray_valid = 1'($urandom); ox = 16'($urandom); dx = 16'($urandom); dy = 16'($urandom);
  endtask

  task automatic finish_ray(int hold);
    logic h; logic [7:0] s; logic [5:0] st; int k;
    for (k = 0; k < MAX_STEPS + 10 && !res_valid; k++) @(negedge clk);
    ray_valid = 0;
    if (!res_valid) begin chk("res_valid_timeout", 0, 1); return; end
    h = res_hit; s = res_shade; st = res_steps;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_stable", {h, s, st}, {res_hit, res_shade, res_steps});
      chk("hold_ray_ready", ray_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("release_ray_ready", ray_ready, 1);
    chk("release_res_valid", res_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ray_ready", ray_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_px", px, 0);
    chk("rst_res_steps", res_steps, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ray_ready", ray_ready, 1);

    // Hit at origin
    mode = 0; lbase = 16'h0080;
    accept(0, 0, 0, 16'h0100, 0, 0); finish_ray(0);
    chk("origin_shade", last_shade, 8'h80);
    chk("origin_steps", last_steps, 0);

    // Hit after four advances along +x
    mode = 2; thr = 16'h0100; lbase = 0;
    accept(0, 0, 0, 16'h0100, 0, 0); finish_ray(1);
    chk("xhit_hit", last_hit, 1);
    chk("xhit_steps", last_steps, 4);
    chk("xhit_px", last_px, 16'h0100);

    // Full miss with a long hold before release
    mode = 1;
    accept(16'h0010, -16'sh0020, 16'h0005, 16'h0040, 16'h0013, -16'sh0101); finish_ray(10);
    chk("miss_steps", last_steps, MAX_STEPS - 1);
    chk("miss_hit", last_hit, 0);

    // Saturated shade
    mode = 2; thr = 16'h0000; lbase = 16'h0150;
    accept(16'h0001, 0, 0, 0, 0, 0); finish_ray(0);
    chk("sat_shade", last_shade, 8'hFF);

    // Reset mid-march abandons the ray
    mode = 1;
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0010, 16'h0010, 16'h0010);
    repeat (4) @(negedge clk);
    ray_valid = 0;
    rst_n = 0; #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_px", px, 0);
    chk("mid_rst_pz", pz, 0);
    chk("mid_rst_ray_ready", ray_ready, 1);
    chk("mid_rst_res_steps", res_steps, 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (MAX_STEPS + 4) @(negedge clk);
    chk("no_stale_result", res_valid, 0);
    mode = 2; thr = 16'h0100; lbase = 16'h0011;
    accept(16'h00C0, 16'h0007, 0, 16'h0100, 0, 0); finish_ray(0);
    chk("after_rst_steps", last_steps, 1);

    // Random rays
    for (int r = 0; r < 200; r++) begin
      int m;
      m = int'($urandom_range(0, 5));
      mode  = (m == 0) ? 0 : (m == 1) ? 1 : 2;
      thr   = 16'($urandom_range(0, 16'h0600)) - 16'sh0300;
      lbase = 16'($urandom_range(0, 16'h01FF));
      accept(16'($urandom_range(0, 16'h0400)) - 16'sh0200, 16'($urandom),
             16'($urandom), 16'($urandom_range(0, 16'h0800)) - 16'sh0400,
             16'($urandom_range(0, 16'h0800)) - 16'sh0400, 16'($urandom));
      finish_ray(int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
